// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a 2-entry in-order result queue and a
// saturating counter of accepted illegal instructions. XLEN must be 32 or 64.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       fmt_out,
    output logic             illegal_out,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    logic [2:0]      fmt_dec;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_dec;

    logic [1:0]      occ;
    logic [1:0]      next_occ;
    logic            push;
    logic            pop;

    logic [XLEN-1:0] head_imm;
    logic [2:0]      head_fmt;
    logic [XLEN-1:0] tail_imm;
    logic [2:0]      tail_fmt;

    // Every immediate fits in a sign-extended 32-bit value, so widen once at the end.
    always_comb begin
        fmt_dec = FMT_ILL;
        imm32   = '0;
        case (instruction[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: fmt_dec = FMT_I;
            7'b0011011: fmt_dec = (XLEN == 64) ? FMT_I : FMT_ILL;
            7'b0100011: fmt_dec = FMT_S;
            7'b1100011: fmt_dec = FMT_B;
            7'b0110111, 7'b0010111: fmt_dec = FMT_U;
            7'b1101111: fmt_dec = FMT_J;
            7'b0110011: fmt_dec = FMT_R;
            7'b0111011: fmt_dec = (XLEN == 64) ? FMT_R : FMT_ILL;
            default:    fmt_dec = FMT_ILL;
        endcase
        case (fmt_dec)
            FMT_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
            FMT_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            FMT_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            FMT_U: imm32 = {instruction[31:12], 12'b0};
            FMT_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        imm_dec        = {XLEN{imm32[31]}};
        imm_dec[31:0]  = imm32;
    end

    assign out_valid = (occ != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign next_occ  = occ + {1'b0, push} - {1'b0, pop};

    // Head is slot 0; on a pop the tail shifts forward unless a new beat
    // lands directly in the head because the queue held only one entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= 2'd0;
            in_ready <= 1'b1;
            head_imm <= '0;
            head_fmt <= FMT_R;
            tail_imm <= '0;
            tail_fmt <= FMT_R;
        end else begin
            occ      <= next_occ;
            in_ready <= (next_occ != 2'd2);
            if (push && (occ == 2'd0 || (pop && occ == 2'd1))) begin
                head_imm <= imm_dec;
                head_fmt <= fmt_dec;
            end else if (pop) begin
                head_imm <= tail_imm;
                head_fmt <= tail_fmt;
            end
            if (push && !pop && occ == 2'd1) begin
                tail_imm <= imm_dec;
                tail_fmt <= fmt_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (clr_cnt) begin
            illegal_cnt <= '0;
        end else if (push && fmt_dec == FMT_ILL && illegal_cnt != {CNT_W{1'b1}}) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    // An empty queue shows all-zero outputs regardless of stale slot contents.
    assign imm_out     = out_valid ? head_imm : '0;
    assign fmt_out     = out_valid ? head_fmt : FMT_R;
    assign illegal_out = out_valid && (head_fmt == FMT_ILL);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table across XLEN=64/32 instances,
// then backpressure, counter saturation/clear and mid-stream reset sequences.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_ready;
    logic        clr_cnt;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [15:0] cnt64;

    logic        in_ready32, out_valid32, illegal32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [15:0] cnt32;

    logic        in_ready_s, out_valid_s, illegal_s;
    logic [63:0] imm_s;
    logic [2:0]  fmt_s;
    logic [1:0]  cnt_s;

    int tests_run    = 0;
    int tests_failed = 0;

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instruction(instruction), .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm64), .fmt_out(fmt64), .illegal_out(illegal64),
        .clr_cnt(clr_cnt), .illegal_cnt(cnt64)
    );

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .instruction(instruction), .out_valid(out_valid32), .out_ready(out_ready),
        .imm_out(imm32), .fmt_out(fmt32), .illegal_out(illegal32),
        .clr_cnt(clr_cnt), .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .instruction(instruction), .out_valid(out_valid_s), .out_ready(out_ready),
        .imm_out(imm_s), .fmt_out(fmt_s), .illegal_out(illegal_s),
        .clr_cnt(clr_cnt), .illegal_cnt(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic [15:0] cnt64;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer one beat for one edge, then sample #1 after that edge.
    task automatic push_beat(input logic [31:0] instr);
        in_valid    = 1'b1;
        instruction = instr;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        instruction = 32'hDEADBEEF;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h00108113, 64'h1,                3'd1, 32'h1,        3'd1, 16'd0};
        vecs[1]  = '{32'h0020A1A3, 64'h3,                3'd2, 32'h3,        3'd2, 16'd0};
        vecs[2]  = '{32'hFE208EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 32'hFFFFFFFC, 3'd3, 16'd0};
        vecs[3]  = '{32'h0080006F, 64'h8,                3'd5, 32'h8,        3'd5, 16'd0};
        vecs[4]  = '{32'h123450B7, 64'h12345000,         3'd4, 32'h12345000, 3'd4, 16'd0};
        vecs[5]  = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 32'h80000000, 3'd4, 16'd0};
        vecs[6]  = '{32'hFFFFFFFF, 64'h0,                3'd7, 32'h0,        3'd7, 16'd1};
        vecs[7]  = '{32'h0010809B, 64'h1,                3'd1, 32'h0,        3'd7, 16'd1};
        vecs[8]  = '{32'h002081B3, 64'h0,                3'd0, 32'h0,        3'd0, 16'd1};
        vecs[9]  = '{32'h002081BB, 64'h0,                3'd0, 32'h0,        3'd7, 16'd1};
        vecs[10] = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 32'hFFFFFFFF, 3'd1, 16'd1};
        vecs[11] = '{32'hFFC12083, 64'hFFFFFFFFFFFFFFFC, 3'd1, 32'hFFFFFFFC, 3'd1, 16'd1};
        vecs[12] = '{32'hFFFFF017, 64'hFFFFFFFFFFFFF000, 3'd4, 32'hFFFFF000, 3'd4, 16'd1};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        instruction = 32'h0;
        out_ready   = 1'b1;
        clr_cnt     = 1'b0;
        #12;
        rst_n = 1'b1;
        check("reset out_valid", 64'(out_valid64), 64'd0);
        check("reset in_ready",  64'(in_ready64),  64'd1);
        check("reset imm",       imm64,            64'd0);
        check("reset fmt",       64'(fmt64),       64'd0);
        check("reset illegal",   64'(illegal64),   64'd0);
        check("reset cnt",       64'(cnt64),       64'd0);

        // The first vector is offered before the first edge after reset release.
        foreach (vecs[i]) begin
            push_beat(vecs[i].instr);
            check($sformatf("v%0d out_valid", i), 64'(out_valid64), 64'd1);
            check($sformatf("v%0d imm64", i), imm64, vecs[i].imm64);
            check($sformatf("v%0d fmt64", i), 64'(fmt64), 64'(vecs[i].fmt64));
            check($sformatf("v%0d illegal64", i), 64'(illegal64), 64'(vecs[i].fmt64 == 3'd7));
            check($sformatf("v%0d imm32", i), 64'(imm32), 64'(vecs[i].imm32));
            check($sformatf("v%0d fmt32", i), 64'(fmt32), 64'(vecs[i].fmt32));
            check($sformatf("v%0d illegal32", i), 64'(illegal32), 64'(vecs[i].fmt32 == 3'd7));
            check($sformatf("v%0d cnt64", i), 64'(cnt64), 64'(vecs[i].cnt64));
            tick();
            check($sformatf("v%0d drained", i), 64'(out_valid64), 64'd0);
        end
        check("table cnt32", 64'(cnt32), 64'd3);

        // Backpressure: A and B fill the queue, C waits, then all drain in order.
        out_ready = 1'b0;
        push_beat(32'h00108113);
        check("bp A head", imm64, 64'h1);
        check("bp A in_ready", 64'(in_ready64), 64'd1);
        push_beat(32'h0020A1A3);
        check("bp full in_ready", 64'(in_ready64), 64'd0);
        in_valid    = 1'b1;
        instruction = 32'h0080006F;
        tick();
        tick();
        check("bp held in_ready", 64'(in_ready64), 64'd0);
        check("bp held head imm", imm64, 64'h1);
        check("bp held head fmt", 64'(fmt64), 64'd1);
        check("bp held out_valid", 64'(out_valid64), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp pop A head", imm64, 64'h3);
        check("bp pop A in_ready", 64'(in_ready64), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp C head imm", imm64, 64'h8);
        check("bp C head fmt", 64'(fmt64), 64'd5);
        check("bp C out_valid", 64'(out_valid64), 64'd1);
        tick();
        check("bp drained", 64'(out_valid64), 64'd0);

        // Counter saturation on CNT_W=2, then clear beating a same-cycle increment.
        in_valid    = 1'b1;
        instruction = 32'hFFFFFFFF;
        repeat (5) tick();
        check("sat cnt2", 64'(cnt_s), 64'd3);
        check("sat cnt16", 64'(cnt64), 64'd6);
        clr_cnt = 1'b1;
        tick();
        clr_cnt  = 1'b0;
        in_valid = 1'b0;
        check("clr cnt2", 64'(cnt_s), 64'd0);
        check("clr cnt16", 64'(cnt64), 64'd0);
        tick();
        check("clr drained", 64'(out_valid64), 64'd0);

        // Mid-stream reset with a full queue takes effect without a clock edge.
        out_ready = 1'b0;
        push_beat(32'hFFFFFFFF);
        push_beat(32'h00108113);
        check("mid full in_ready", 64'(in_ready64), 64'd0);
        check("mid full cnt", 64'(cnt64), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 64'(out_valid64), 64'd0);
        check("mid rst in_ready", 64'(in_ready64), 64'd1);
        check("mid rst imm", imm64, 64'd0);
        check("mid rst illegal", 64'(illegal64), 64'd0);
        check("mid rst cnt", 64'(cnt64), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post rst empty", 64'(out_valid64), 64'd0);
        out_ready = 1'b1;
        push_beat(32'h123450B7);
        check("post rst imm", imm64, 64'h12345000);
        check("post rst fmt", 64'(fmt64), 64'd4);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
